// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush and halt drain sequencer; define ID_EX_PERF_EN for issue/bubble counters.
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              id_alu_src,
    input  logic              id_mem_to_reg,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_halt,
    input  logic [2:0]        id_alu_op,
    input  logic [1:0]        id_jal_type,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_alu_src,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_halt,
    output logic [2:0]        ex_alu_op,
    output logic [1:0]        ex_jal_type,
    output logic              frontend_hold,
    output logic              halted
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       halt;
        logic [2:0] alu_op;
        logic [1:0] jal_type;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } data_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    ctrl_t         ctrl_q, ctrl_d, id_ctrl;
    data_t         data_q, data_d, id_data;
    logic          load, bubble, capture;

    always_comb begin
        id_ctrl = {id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write,
                   id_branch, id_halt, id_alu_op, id_jal_type};
        id_data = {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7};
        load    = state_q == RUN && !flush && !stall;
        bubble  = state_q != RUN || flush;
        capture = load && id_valid && id_halt;
        valid_d = bubble ? 1'b0 : stall ? valid_q : id_valid;
        ctrl_d  = bubble ? '0 : stall ? ctrl_q : id_valid ? id_ctrl : '0;
        data_d  = load ? id_data : data_q;
        state_d = capture ? DRAIN : (state_q == DRAIN && cnt_q == '0) ? HALTED : state_q;
        cnt_d   = capture ? CW'(DRAIN_CYCLES - 1)
                : (state_q == DRAIN && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign ex_valid = valid_q;
    assign {ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write,
            ex_branch, ex_halt, ex_alu_op, ex_jal_type} = ctrl_q;
    assign {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7} = data_q;
    assign frontend_hold = state_q != RUN;
    assign halted        = state_q == HALTED;

`ifdef ID_EX_PERF_EN
    logic [31:0] issue_q, issue_d, bub_q, bub_d;

    always_comb begin
        issue_d = (load && id_valid && issue_q != '1) ? issue_q + 32'd1 : issue_q;
        bub_d   = (state_q == RUN && (flush || (!stall && !id_valid)) && bub_q != '1)
                ? bub_q + 32'd1 : bub_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
            bub_q   <= '0;
        end else begin
            issue_q <= issue_d;
            bub_q   <= bub_d;
        end
    end

    assign perf_issue_cnt  = issue_q;
    assign perf_bubble_cnt = bub_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table vectors, halt/reset sequences and random stimulus against a reference model.
module tb_id_ex_stage;
    localparam int DW    = 32;
    localparam int DRAIN = 3;
    localparam logic [11:0] HALT_BIT = 12'h020;

    logic clk = 1'b0;
    logic rst_n, stall, flush, id_valid;
    logic [11:0]  in_ctl;
    logic [152:0] in_dp;
    logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm, ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
    logic [2:0] id_funct3, ex_funct3, id_alu_op, ex_alu_op;
    logic [6:0] id_funct7, ex_funct7;
    logic [1:0] id_jal_type, ex_jal_type;
    logic id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_halt;
    logic ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_halt;
    logic ex_valid, frontend_hold, halted;
    logic [11:0]  ex_ctl;
    logic [152:0] ex_dp;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_issue_cnt, perf_bubble_cnt;
`endif

    assign {id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write,
            id_branch, id_halt, id_alu_op, id_jal_type} = in_ctl;
    assign {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7} = in_dp;
    assign ex_ctl = {ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_branch, ex_halt, ex_alu_op, ex_jal_type};
    assign ex_dp = {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_halt(id_halt), .id_alu_op(id_alu_op), .id_jal_type(id_jal_type),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_halt(ex_halt), .ex_alu_op(ex_alu_op), .ex_jal_type(ex_jal_type),
        .frontend_hold(frontend_hold), .halted(halted)
`ifdef ID_EX_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    int vectors = 0, miscompares = 0;

    // Reference model: halt_age counts edges since a halt was accepted (-1 = none).
    logic         m_valid;
    logic [11:0]  m_ctl;
    logic [152:0] m_dp;
    int           m_age;
    longint       m_issue, m_bub;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ctl = '0; m_dp = '0; m_age = -1; m_issue = 0; m_bub = 0;
    endtask

    task automatic model_step();
        if (m_age >= 0) begin
            m_valid = 1'b0; m_ctl = '0; m_age++;
        end else if (flush) begin
            m_valid = 1'b0; m_ctl = '0; m_bub++;
        end else if (!stall) begin
            m_valid = id_valid;
            m_ctl   = id_valid ? in_ctl : 12'h0;
            m_dp    = in_dp;
            if (id_valid) m_issue++; else m_bub++;
            if (id_valid && (in_ctl & HALT_BIT) != 0) m_age = 0;
        end
        if (m_issue > 64'hFFFF_FFFF) m_issue = 64'hFFFF_FFFF;
        if (m_bub > 64'hFFFF_FFFF) m_bub = 64'hFFFF_FFFF;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, ex_valid, m_valid);
        check({tag, ".ctl"}, ex_ctl, m_ctl);
        check({tag, ".dp"}, ex_dp, m_dp);
        check({tag, ".hold"}, frontend_hold, m_age >= 0);
        check({tag, ".halted"}, halted, m_age >= DRAIN);
`ifdef ID_EX_PERF_EN
        check({tag, ".issue"}, perf_issue_cnt, m_issue[31:0]);
        check({tag, ".bubble"}, perf_bubble_cnt, m_bub[31:0]);
`endif
    endtask

    task automatic drive(input logic s, input logic f, input logic v,
                         input logic [11:0] c, input logic [152:0] d);
        stall = s; flush = f; id_valid = v; in_ctl = c; in_dp = d;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [152:0] rand_dp();
        return {$urandom, $urandom, $urandom, $urandom, 25'($urandom)};
    endfunction

    typedef struct {
        logic        s, f, v;
        logic [31:0] pc;
        logic [11:0] ctl;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [11:0] e_ctl;
        logic        e_hold;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; id_valid = 0; in_ctl = '0; in_dp = '0;
        model_reset();
        #3;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{0, 0, 1, 32'h40, 12'h208, 1, 32'h40, 12'h208, 0};
        tbl[1] = '{1, 0, 1, 32'h44, 12'h0C3, 1, 32'h40, 12'h208, 0};
        tbl[2] = '{1, 0, 0, 32'h44, 12'h0C3, 1, 32'h40, 12'h208, 0};
        tbl[3] = '{1, 0, 1, 32'h44, 12'hFFF, 1, 32'h40, 12'h208, 0};
        tbl[4] = '{0, 0, 1, 32'h44, 12'h000, 1, 32'h44, 12'h000, 0};
        tbl[5] = '{1, 1, 1, 32'h48, 12'h080, 0, 32'h44, 12'h000, 0};
        tbl[6] = '{0, 1, 1, 32'h4C, 12'h020, 0, 32'h44, 12'h000, 0};
        tbl[7] = '{0, 0, 0, 32'h50, 12'hFFF, 0, 32'h50, 12'h000, 0};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].ctl, {tbl[i].pc, 121'd0});
            check($sformatf("tbl%0d.valid", i), ex_valid, tbl[i].e_valid);
            check($sformatf("tbl%0d.pc", i), ex_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d.ctl", i), ex_ctl, tbl[i].e_ctl);
            check($sformatf("tbl%0d.hold", i), frontend_hold, tbl[i].e_hold);
        end

        // Halt capture and drain to halted, with ID activity ignored throughout.
        drive(0, 0, 1, HALT_BIT, {32'h60, 121'd0});
        check("halt.k.valid", ex_valid, 1'b1);
        check("halt.k.ctl", ex_ctl, HALT_BIT);
        check("halt.k.hold", frontend_hold, 1'b1);
        check("halt.k.halted", halted, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            drive(1'($urandom), 1'($urandom), 1'b1, 12'($urandom) | HALT_BIT, rand_dp());
            check($sformatf("halt.k+%0d.valid", e), ex_valid, 1'b0);
            check($sformatf("halt.k+%0d.hold", e), frontend_hold, 1'b1);
            check($sformatf("halt.k+%0d.halted", e), halted, e >= 3);
        end
        do_reset("rst_halted");

        // Reset mid-drain after a known mix of loads, flushes and a stall.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 12'h201, rand_dp());
        drive(0, 1, 1, 12'h201, rand_dp());
        drive(1, 0, 1, 12'h201, rand_dp());
        drive(1, 1, 1, 12'h201, rand_dp());
        drive(0, 0, 1, HALT_BIT, rand_dp());
        drive(0, 0, 1, 12'h000, rand_dp());
        check("drain.hold", frontend_hold, 1'b1);
`ifdef ID_EX_PERF_EN
        check("perf.issue5", perf_issue_cnt, 32'd5);
        check("perf.bubble2", perf_bubble_cnt, 32'd2);
`endif
        do_reset("rst_drain");

        // Random stimulus against the model, resetting after halts.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                  (12'($urandom) & ~HALT_BIT) | (($urandom_range(0, 24) == 0) ? HALT_BIT : 12'h0),
                  rand_dp());
            check_model($sformatf("rnd%0d", n));
            if (m_age >= DRAIN + 2 || (m_age == 1 && $urandom_range(0, 2) == 0))
                do_reset($sformatf("rnd_rst%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
